rom_loader: RTL and testbench

Sequential reader for the toolchain-generated boot ROM. After `start`, it walks the ROM byte address space from 0 and copies every byte into system memory through a ready/valid write port. It stops at the address where the ROM flags `done`, then reports completion. It sits between the combinational ROM and the memory arbiter and runs before the CPU is released from boot.

---
 rtl/rom_loader.sv | 140 ++++++++++++++
 tb/tb_rom_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Copies a combinational boot ROM into memory, one byte per FETCH/WRITE pair, until rom_done.
// Define ROM_LOADER_CHECKSUM_EN to get a running mod-256 checksum of accepted bytes.
module rom_loader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned MAX_BYTES = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [31:0]           rom_address,
  input  logic [7:0]            rom_byte,
  input  logic                  rom_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_write,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  load_complete,
  output logic                  load_error,
  output logic [31:0]           bytes_loaded,
  output logic [7:0]            checksum
);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

  localparam logic [31:0] LimitM1 = 32'(MAX_BYTES - 1);

  state_e                  state_q, state_d;
  logic [31:0]             rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]              mem_data_q, mem_data_d;
  logic                    mem_write_q, mem_write_d;
  logic                    last_q, last_d;
  logic                    limit_q, limit_d;
  logic                    err_q, err_d;
  logic [31:0]             count_q, count_d;
  logic                    clear_stats, accept, at_limit;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = mem_write_q;
    last_d      = last_q;
    limit_d     = limit_q;
    err_d       = err_q;
    count_d     = count_q;
    clear_stats = 1'b0;
    accept      = 1'b0;
    at_limit    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          clear_stats = 1'b1;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        at_limit    = (count_q == LimitM1);
        mem_data_d  = rom_byte;
        mem_addr_d  = BASE_ADDR + ADDR_WIDTH'(rom_addr_q);
        last_d      = rom_done || at_limit;
        // Remember whether the limit, not the ROM, ended the load.
        limit_d     = at_limit && !rom_done;
        mem_write_d = 1'b1;
        state_d     = StWrite;
      end
      StWrite: begin
        if (mem_ready) begin
          accept      = 1'b1;
          mem_write_d = 1'b0;
          count_d     = count_q + 32'd1;
          if (last_q) begin
            err_d   = limit_q;
            state_d = StDone;
          end else begin
            rom_addr_d = rom_addr_q + 32'd1;
            state_d    = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear_stats) begin
      rom_addr_d = '0;
      count_d    = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rom_addr_q  <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      last_q      <= 1'b0;
      limit_q     <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      last_q      <= last_d;
      limit_q     <= limit_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + mem_data_q;
    end
  end
  assign checksum = sum_q;
`else
  assign checksum = 8'd0;
`endif

  assign rom_address   = rom_addr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign mem_write     = mem_write_q;
  assign busy          = (state_q == StFetch) || (state_q == StWrite);
  assign load_complete = (state_q == StDone);
  assign load_error    = err_q;
  assign bytes_loaded  = count_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table vectors, backpressure/reset sequences, random loads.
module tb_rom_loader;
  localparam logic [31:0] Base = 32'h100;
  localparam int MaxB = 8;

  logic        clk = 1'b0;
  logic        reset, start, rom_done, mem_write, mem_ready;
  logic        busy, load_complete, load_error;
  logic [31:0] rom_address, mem_addr, bytes_loaded;
  logic [7:0]  rom_byte, mem_data, checksum;

  logic [7:0]  rom_mem [16];
  int          done_at;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] got_addr [$];
  logic [7:0]  got_data [$];

  typedef struct {
    logic [63:0] bytes;
    int          done_at;
    int          exp_n;
    bit          exp_err;
    logic [7:0]  exp_sum;
    int          exp_cycles;
    bit          busy_start;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  assign rom_byte = (rom_address < 32'd16) ? rom_mem[rom_address[3:0]] : 8'hEE;
  assign rom_done = (done_at >= 0) && (rom_address == 32'(done_at));

  rom_loader #(.ADDR_WIDTH(32), .BASE_ADDR(Base), .MAX_BYTES(MaxB)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_address(rom_address),
    .rom_byte(rom_byte), .rom_done(rom_done), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write(mem_write), .mem_ready(mem_ready), .busy(busy),
    .load_complete(load_complete), .load_error(load_error),
    .bytes_loaded(bytes_loaded), .checksum(checksum)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] csum(input logic [7:0] s);
`ifdef ROM_LOADER_CHECKSUM_EN
    return s;
`else
    return 8'd0;
`endif
  endfunction

  // Spec-level expectation: bytes 0..done are copied unless the limit comes first.
  task automatic model(output int n, output bit err, output logic [7:0] sum);
    bit hit;
    hit = (done_at >= 0) && (done_at < MaxB);
    n   = hit ? done_at + 1 : MaxB;
    err = !hit;
    sum = 8'd0;
    for (int i = 0; i < n; i++) sum = sum + rom_mem[i];
  endtask

  task automatic do_load(input int ready_pct, input int stall_idx, input int stall_len,
                         input bit busy_start, output int cycles, output int stalls);
    int   stalled;
    bit   busy_bad, hold_bad, timeout, prev_pending;
    logic [31:0] pa;
    logic [7:0]  pd;
    stalled = 0; busy_bad = 0; hold_bad = 0; timeout = 1; prev_pending = 0;
    pa = '0; pd = '0; cycles = 0; stalls = 0;
    got_addr.delete();
    got_data.delete();
    start = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_bytes_cleared", bytes_loaded, 0);
    chk("start_complete_low", load_complete, 0);
    chk("start_error_cleared", load_error, 0);
    chk("start_checksum_cleared", checksum, 0);
    chk("start_rom_addr_zero", rom_address, 0);
    chk("start_busy", busy, 1);
    for (int c = 0; c < 400; c++) begin
      mem_ready = ($urandom_range(99) < ready_pct);
      if (stall_idx >= 0 && mem_write && mem_addr == Base + 32'(stall_idx) &&
          stalled < stall_len) begin
        mem_ready = 1'b0;
        stalled++;
      end
      start = (busy_start && c == 1);
      if (prev_pending && (mem_write !== 1'b1 || mem_addr !== pa || mem_data !== pd))
        hold_bad = 1;
      if (busy !== 1'b1) busy_bad = 1;
      @(negedge clk);
      if (mem_write && mem_ready) begin
        got_addr.push_back(mem_addr);
        got_data.push_back(mem_data);
      end else if (mem_write) begin
        stalls++;
      end
      prev_pending = mem_write && !mem_ready;
      pa = mem_addr;
      pd = mem_data;
      @(posedge clk); #1;
      cycles++;
      if (load_complete) begin
        timeout = 0;
        break;
      end
    end
    start = 1'b0;
    chk("load_timeout", timeout, 0);
    chk("busy_during_load", busy_bad, 0);
    chk("write_held_stable", hold_bad, 0);
  endtask

  task automatic check_result(input int exp_n, input bit exp_err, input logic [7:0] exp_sum,
                              input int exp_cycles, input int cycles, input int stalls);
    chk("write_count", got_addr.size(), exp_n);
    for (int i = 0; i < got_addr.size() && i < exp_n; i++) begin
      chk("write_addr", got_addr[i], Base + 32'(i));
      chk("write_data", got_data[i], rom_mem[i]);
    end
    chk("bytes_loaded", bytes_loaded, exp_n);
    chk("load_error", load_error, exp_err);
    chk("load_complete", load_complete, 1);
    chk("busy_done", busy, 0);
    chk("mem_write_done", mem_write, 0);
    chk("checksum", checksum, csum(exp_sum));
    chk("cycles_vs_stalls", cycles, 2 * exp_n + stalls);
    if (exp_cycles >= 0) chk("completion_edge", cycles, exp_cycles);
  endtask

  task automatic fill_rom(input logic [63:0] bytes, input int d);
    for (int i = 0; i < 16; i++)
      rom_mem[i] = (i < 8) ? bytes[8*i +: 8] : 8'(8'hA0 + i);
    done_at = d;
  endtask

  initial begin
    int cyc, st, n, acc;
    bit err, wr_bad;
    logic [7:0] sum;
    logic [63:0] rnd;

    vecs[0] = '{64'h0000_0000_0100_140E, 3, 4, 1'b0, 8'h23, 8, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_0048, 0, 1, 1'b0, 8'h48, 2, 1'b0};
    vecs[2] = '{64'h0807_0605_0403_0201, -1, 8, 1'b1, 8'h24, 16, 1'b0};
    vecs[3] = '{64'h0807_0605_0403_0201, 7, 8, 1'b0, 8'h24, 16, 1'b0};
    vecs[4] = '{64'h0807_0605_0403_0201, 12, 8, 1'b1, 8'h24, 16, 1'b0};
    vecs[5] = '{64'h0000_0000_0100_140E, 3, 4, 1'b0, 8'h23, 8, 1'b1};

    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
    fill_rom(64'h0, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_complete", load_complete, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_bytes", bytes_loaded, 0);
    chk("reset_rom_addr", rom_address, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back loads: every one after the first restarts from DONE.
    for (int v = 0; v < 6; v++) begin
      fill_rom(vecs[v].bytes, vecs[v].done_at);
      do_load(100, -1, 0, vecs[v].busy_start, cyc, st);
      check_result(vecs[v].exp_n, vecs[v].exp_err, vecs[v].exp_sum, vecs[v].exp_cycles,
                   cyc, st);
    end

    fill_rom(64'h0000_0000_0100_140E, 3);
    do_load(100, 1, 3, 1'b0, cyc, st);
    chk("stall_cycles", st, 3);
    check_result(4, 1'b0, 8'h23, 11, cyc, st);

    do_load(100, -1, 0, 1'b0, cyc, st);
    acc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && acc < 2; c++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      if (mem_write && mem_ready) acc++;
      @(posedge clk); #1;
    end
    chk("reset_test_accepts", acc, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_mem_write", mem_write, 0);
    chk("midreset_mem_addr", mem_addr, 0);
    chk("midreset_mem_data", mem_data, 0);
    chk("midreset_rom_addr", rom_address, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_bytes", bytes_loaded, 0);
    chk("midreset_complete", load_complete, 0);
    chk("midreset_checksum", checksum, 0);
    reset = 1'b0;
    wr_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_write !== 1'b0 || busy !== 1'b0) wr_bad = 1;
      @(posedge clk); #1;
    end
    chk("idle_after_reset", wr_bad, 0);
    do_load(100, -1, 0, 1'b0, cyc, st);
    check_result(4, 1'b0, 8'h23, 8, cyc, st);

    for (int r = 0; r < 20; r++) begin
      rnd = {$urandom, $urandom};
      fill_rom(rnd, int'($urandom_range(12)) - 1);
      for (int i = 8; i < 16; i++) rom_mem[i] = 8'($urandom);
      model(n, err, sum);
      do_load(int'($urandom_range(100, 30)), -1, 0, 1'($urandom_range(1)), cyc, st);
      check_result(n, err, sum, -1, cyc, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
